pipe_perf_monitor: RTL and testbench
====================================

Name: pipe_perf_monitor

Overview:
- Synthesizable performance monitor beside the pipelined CPU; taps hazard, branch and writeback signals.
- Counts cycles, stall cycles, flushes and retired instructions, and raises a cycle-limit done flag.
- On request, snapshots all counters and streams them out one word per handshake over a valid/ready port.
- Moves the simulation-only stall/flush bookkeeping into hardware so benches and on-chip debug read identical numbers.

Parameters:
- CNT_W, 32, counter and output data width.
- MAX_CYCLES, 100, counted-cycle limit that sets done_o; 0 disables the limit.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  CPU running; counting enabled only while high.
- pc_write_i  in  1  PC write enable from hazard unit; 0 = PC held.
- branch_i  in  1  branch taken this cycle; IF/ID flushed.
- wb_valid_i  in  1  valid (non-bubble) instruction in WB this cycle.
- clear_i  in  1  zero live counters and done_o.
- snap_req_i  in  1  request snapshot and readout.
- out_valid_o  out  1  out_data_o valid.
- out_ready_i  in  1  consumer accepts the word.
- out_data_o  out  CNT_W  snapshot word.
- out_idx_o  out  2  word index: 0 cycles, 1 stalls, 2 flushes, 3 retired.
- busy_o  out  1  readout in progress (state STREAM).
- done_o  out  1  cycle limit reached; sticky.

Behaviour:
- Reset (rst_i=1 at an edge): all four live counters = 0, snapshot regs = 0, state IDLE, out_valid_o=0, out_idx_o=0, out_data_o=0, busy_o=0, done_o=0. Reset overrides everything, including mid-stream; the stream aborts with no further valid.
- Counting enable: cnt_en = start_i & ~done_o. When cnt_en=0 no live counter changes.
- Per enabled cycle:
  - cycle_cnt +1.
  - stall_cnt +1 iff pc_write_i=0 & branch_i=0. A hold caused by a branch is not a stall.
  - flush_cnt +1 iff branch_i=1.
  - retire_cnt +1 iff wb_valid_i=1.
  - The four increments are independent and may occur in the same cycle.
- Width: all counters are CNT_W bits and saturate at all-ones; no wrap.
- done_o: set at the edge where cycle_cnt becomes MAX_CYCLES (when MAX_CYCLES≠0). Visible the cycle after the MAX_CYCLES-th counted cycle. Once set, it freezes all live counters. Cleared only by rst_i or clear_i.
- clear_i: zeroes live counters and done_o at the edge. It has priority over any same-cycle increment, so the post-edge value is 0. It does not touch snapshot regs or an active stream.
- FSM IDLE:
  - snap_req_i=1 latches snapshot regs with the live counter values as registered before this edge's increment.
  - The FSM enters STREAM with out_idx_o=0 and out_valid_o=1 from the next cycle.
  - If clear_i is also asserted, the snapshot still takes the pre-clear values.
- FSM STREAM:
  - out_data_o = snapshot[out_idx_o], held stable while out_valid_o & ~out_ready_i.
  - A handshake (valid & ready) at idx<3 advances idx the next cycle; valid stays high.
  - A handshake at idx=3 returns to IDLE; out_valid_o=0 and out_idx_o=0 next cycle.
  - snap_req_i is ignored in STREAM.
  - Live counting continues in parallel.
- busy_o = (state==STREAM).
- Latency: snap_req_i to first valid word = 1 cycle. Minimum full readout = 4 cycles with out_ready_i held high.

Test Plan:
- Basic counting: reset, start_i=1 for 10 cycles, pc_write_i=1, branch_i=0, wb_valid_i=1 from cycle 4 → snapshot streams 10, 0, 0, 6 with idx 0..3.
- Stall vs flush: 3 cycles pc_write_i=0/branch_i=0, then 2 cycles pc_write_i=0/branch_i=1 → stalls=3, flushes=2, cycles=5.
- Cycle limit: MAX_CYCLES=100, start_i held → done_o rises after the 100th counted cycle; cycle_cnt stays 100 for 20 more cycles; clear_i → done_o=0, counting resumes from 0.
- Backpressure: snapshot with out_ready_i low 5 cycles at idx 1 → out_data_o/out_idx_o stable, valid held; then ready high → idx 2, 3, then valid=0; a snap_req_i during STREAM produces no second stream.
- Simultaneous events: clear_i and snap_req_i on the same edge with cycle_cnt=42 → streamed word 0 = 42, live cycle_cnt=0 next cycle.
- Saturation and mid-stream reset: CNT_W=4, 20 counted cycles → cycles=15; rst_i asserted at idx 2 → next cycle out_valid_o=0, busy_o=0, counters 0.

Source files
------------

// File: rtl/pipe_perf_monitor_if.sv
// Snapshot readout port of the pipeline performance monitor: one counter word
// per valid/ready handshake, tagged with its index.
interface pipe_perf_monitor_if #(
   parameter int CNT_W = 32
);
   logic             out_valid_o;
   logic             out_ready_i;
   logic [CNT_W-1:0] out_data_o;
   logic [1:0]       out_idx_o;

   modport master (
      output out_valid_o,
      output out_data_o,
      output out_idx_o,
      input  out_ready_i
   );

   modport slave (
      input  out_valid_o,
      input  out_data_o,
      input  out_idx_o,
      output out_ready_i
   );
endinterface

// File: rtl/pipe_perf_monitor.sv
// Counts cycles, stalls, flushes and retirements of the CPU pipeline and
// streams a frozen snapshot of the four counters over a valid/ready port.
module pipe_perf_monitor #(
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 100
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                pc_write_i,
   input  logic                branch_i,
   input  logic                wb_valid_i,
   input  logic                clear_i,
   input  logic                snap_req_i,
   pipe_perf_monitor_if.master rd,
   output logic                busy_o,
   output logic                done_o
);

   typedef enum logic {IDLE, STREAM} state_t;

   localparam logic [63:0] MAXC = 64'(MAX_CYCLES);

   state_t           state, state_nxt;
   logic [1:0]       idx, idx_nxt;
   logic             take_snap;
   logic             cnt_en;
   logic             done_hit;
   logic [CNT_W-1:0] cyc_inc;
   logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt, retire_cnt;
   logic [CNT_W-1:0] snap [4];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
      if (en && (v != '1))
         return v + CNT_W'(1);
      return v;
   endfunction

   always_comb begin
      cnt_en   = start_i & ~done_o;
      cyc_inc  = sat_inc(cyc_cnt, 1'b1);
      // A saturated counter never equals a limit beyond its range, so done never fires then.
      done_hit = cnt_en && (MAX_CYCLES != 0) && (64'(cyc_inc) == MAXC);
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      take_snap = 1'b0;
      case (state)
         IDLE: begin
            if (snap_req_i) begin
               take_snap = 1'b1;
               state_nxt = STREAM;
               idx_nxt   = 2'd0;
            end
         end
         STREAM: begin
            if (rd.out_ready_i) begin
               if (idx == 2'd3) begin
                  state_nxt = IDLE;
                  idx_nxt   = 2'd0;
               end else begin
                  idx_nxt = idx + 2'd1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = 2'd0;
         end
      endcase

      rd.out_valid_o = (state == STREAM);
      rd.out_idx_o   = idx;
      rd.out_data_o  = (state == STREAM) ? snap[idx] : '0;
      busy_o         = (state == STREAM);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         idx   <= 2'd0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Snapshot takes the registered values, so it sees pre-increment and pre-clear counts.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cyc_cnt    <= '0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         retire_cnt <= '0;
         done_o     <= 1'b0;
         for (int i = 0; i < 4; i++)
            snap[i] <= '0;
      end else begin
         if (take_snap) begin
            snap[0] <= cyc_cnt;
            snap[1] <= stall_cnt;
            snap[2] <= flush_cnt;
            snap[3] <= retire_cnt;
         end
         if (clear_i) begin
            cyc_cnt    <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
            done_o     <= 1'b0;
         end else if (cnt_en) begin
            cyc_cnt    <= cyc_inc;
            stall_cnt  <= sat_inc(stall_cnt, ~pc_write_i & ~branch_i);
            flush_cnt  <= sat_inc(flush_cnt, branch_i);
            retire_cnt <= sat_inc(retire_cnt, wb_valid_i);
            if (done_hit)
               done_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: a 32-bit instance with a 100-cycle limit and a
// 4-bit unlimited instance share stimulus and are checked against an event-count model.
module tb_pipe_perf_monitor;

   logic clk = 1'b0;
   logic rst, start, pc_write, branch, wb_valid, clear, snap_req, out_ready;
   logic busy0, done0, busy1, done1;
   int   n_chk  = 0;
   int   n_fail = 0;

   pipe_perf_monitor_if #(.CNT_W(32)) bus0 ();
   pipe_perf_monitor_if #(.CNT_W(4))  bus1 ();
   assign bus0.out_ready_i = out_ready;
   assign bus1.out_ready_i = out_ready;

   always #5 clk = ~clk;

   pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLES(100)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .pc_write_i(pc_write),
      .branch_i(branch), .wb_valid_i(wb_valid), .clear_i(clear),
      .snap_req_i(snap_req), .rd(bus0), .busy_o(busy0), .done_o(done0)
   );

   pipe_perf_monitor #(.CNT_W(4), .MAX_CYCLES(0)) dut_s (
      .clk_i(clk), .rst_i(rst), .start_i(start), .pc_write_i(pc_write),
      .branch_i(branch), .wb_valid_i(wb_valid), .clear_i(clear),
      .snap_req_i(snap_req), .rd(bus1), .busy_o(busy1), .done_o(done1)
   );

   // Model: true event counts per instance; visible value is the count clipped to the width.
   longint mc    [2][4];
   longint msnap [2][4];
   bit     mstr  [2];
   int     midx  [2];
   bit     mdone [2];
   longint satv  [2] = '{64'h0000_0000_FFFF_FFFF, 64'd15};
   longint maxc  [2] = '{64'd100, 64'd0};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint vis(input int m, input int k);
      return (mc[m][k] > satv[m]) ? satv[m] : mc[m][k];
   endfunction

   always @(negedge clk) begin
      check("valid0", 64'(bus0.out_valid_o), 64'(mstr[0]));
      check("busy0",  64'(busy0),            64'(mstr[0]));
      check("idx0",   64'(bus0.out_idx_o),   64'(midx[0]));
      check("done0",  64'(done0),            64'(mdone[0]));
      if (mstr[0]) check("data0", 64'(bus0.out_data_o), 64'(msnap[0][midx[0]]));
      check("valid1", 64'(bus1.out_valid_o), 64'(mstr[1]));
      check("busy1",  64'(busy1),            64'(mstr[1]));
      check("idx1",   64'(bus1.out_idx_o),   64'(midx[1]));
      check("done1",  64'(done1),            64'(mdone[1]));
      if (mstr[1]) check("data1", 64'(bus1.out_data_o), 64'(msnap[1][midx[1]]));

      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            for (int k = 0; k < 4; k++) begin
               mc[m][k]    = 0;
               msnap[m][k] = 0;
            end
            mstr[m] = 1'b0; midx[m] = 0; mdone[m] = 1'b0;
         end else begin
            if (!mstr[m]) begin
               if (snap_req) begin
                  for (int k = 0; k < 4; k++) msnap[m][k] = vis(m, k);
                  mstr[m] = 1'b1; midx[m] = 0;
               end
            end else if (out_ready) begin
               if (midx[m] == 3) begin
                  mstr[m] = 1'b0; midx[m] = 0;
               end else begin
                  midx[m] = midx[m] + 1;
               end
            end
            if (clear) begin
               for (int k = 0; k < 4; k++) mc[m][k] = 0;
               mdone[m] = 1'b0;
            end else if (start && !mdone[m]) begin
               mc[m][0] = mc[m][0] + 1;
               if (!pc_write && !branch) mc[m][1] = mc[m][1] + 1;
               if (branch)   mc[m][2] = mc[m][2] + 1;
               if (wb_valid) mc[m][3] = mc[m][3] + 1;
               if (maxc[m] != 0 && mc[m][0] == maxc[m]) mdone[m] = 1'b1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic s, input logic p, input logic b, input logic w);
      start = s; pc_write = p; branch = b; wb_valid = w;
   endtask

   task automatic do_clear();
      clear = 1'b1; step(); clear = 1'b0;
   endtask

   task automatic read_stream(input logic with_clear,
                              output logic [3:0][31:0] w0, output logic [3:0][3:0] w1);
      snap_req = 1'b1; out_ready = 1'b1; clear = with_clear;
      step();
      snap_req = 1'b0; clear = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("stream_idx", 64'(bus0.out_idx_o), 64'(k));
         w0[k] = bus0.out_data_o;
         w1[k] = bus1.out_data_o;
         step();
      end
      check("stream_end_valid", 64'(bus0.out_valid_o), 64'd0);
   endtask

   logic [3:0][31:0] w0;
   logic [3:0][3:0]  w1;

   initial begin
      rst = 1'b1; clear = 1'b0; snap_req = 1'b0; out_ready = 1'b0;
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      step(); step();
      rst = 1'b0;
      check("rst_valid", 64'(bus0.out_valid_o), 64'd0);
      check("rst_idx",   64'(bus0.out_idx_o),   64'd0);
      check("rst_data",  64'(bus0.out_data_o),  64'd0);
      check("rst_busy",  64'(busy0),            64'd0);
      check("rst_done",  64'(done0),            64'd0);

      // Basic counting
      for (int i = 0; i < 10; i++) begin
         set_in(1'b1, 1'b1, 1'b0, logic'(i >= 4));
         step();
      end
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      read_stream(1'b0, w0, w1);
      check("basic_cycles",  64'(w0[0]), 64'd10);
      check("basic_stalls",  64'(w0[1]), 64'd0);
      check("basic_flushes", 64'(w0[2]), 64'd0);
      check("basic_retired", 64'(w0[3]), 64'd6);
      check("basic_cycles_w4", 64'(w1[0]), 64'd10);

      // Stall versus flush
      do_clear();
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) step();
      set_in(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (2) step();
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      read_stream(1'b0, w0, w1);
      check("sf_cycles",  64'(w0[0]), 64'd5);
      check("sf_stalls",  64'(w0[1]), 64'd3);
      check("sf_flushes", 64'(w0[2]), 64'd2);
      check("sf_retired", 64'(w0[3]), 64'd0);

      // Cycle limit
      do_clear();
      set_in(1'b1, 1'b1, 1'b0, 1'b1);
      for (int k = 1; k <= 100; k++) begin
         step();
         if (k == 99)  check("limit_done_99",  64'(done0), 64'd0);
         if (k == 100) check("limit_done_100", 64'(done0), 64'd1);
      end
      repeat (20) step();
      read_stream(1'b0, w0, w1);
      check("limit_cycles",    64'(w0[0]), 64'd100);
      check("limit_retired",   64'(w0[3]), 64'd100);
      check("sat_cycles_w4",   64'(w1[0]), 64'd15);
      check("sat_retired_w4",  64'(w1[3]), 64'd15);
      check("limit_done_hold", 64'(done0), 64'd1);
      do_clear();
      check("limit_done_clr", 64'(done0), 64'd0);
      repeat (7) step();
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      read_stream(1'b0, w0, w1);
      check("limit_resume", 64'(w0[0]), 64'd7);

      // Backpressure at idx 1, plus a snapshot request while streaming
      do_clear();
      set_in(1'b1, 1'b0, 1'b0, 1'b1);
      repeat (3) step();
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      snap_req = 1'b1; out_ready = 1'b1;
      step();
      snap_req = 1'b0;
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         snap_req = logic'(i == 2);
         step();
         check("bp_idx",   64'(bus0.out_idx_o),   64'd1);
         check("bp_valid", 64'(bus0.out_valid_o), 64'd1);
         check("bp_data",  64'(bus0.out_data_o),  64'd3);
      end
      snap_req = 1'b0; out_ready = 1'b1;
      step();
      check("bp_idx2", 64'(bus0.out_idx_o), 64'd2);
      step();
      check("bp_idx3", 64'(bus0.out_idx_o), 64'd3);
      step();
      check("bp_end_valid", 64'(bus0.out_valid_o), 64'd0);
      step();
      check("bp_no_restream", 64'(busy0), 64'd0);

      // Clear and snapshot on the same edge
      do_clear();
      set_in(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (42) step();
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      read_stream(1'b1, w0, w1);
      check("simul_word0", 64'(w0[0]), 64'd42);
      read_stream(1'b0, w0, w1);
      check("simul_live_zero", 64'(w0[0]), 64'd0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         rst       = logic'($urandom_range(0, 299) == 0);
         clear     = logic'($urandom_range(0, 149) == 0);
         snap_req  = logic'($urandom_range(0, 7) == 0);
         out_ready = logic'($urandom_range(0, 9) < 7);
         set_in(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 2) != 0),
                logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 1)));
         step();
      end
      rst = 1'b1; clear = 1'b0; snap_req = 1'b0; out_ready = 1'b1;
      step();
      rst = 1'b0;

      // Saturation and reset in the middle of a stream
      set_in(1'b1, 1'b0, 1'b0, 1'b1);
      repeat (20) step();
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      snap_req = 1'b1;
      step();
      snap_req = 1'b0;
      check("sat20_cycles_w4", 64'(bus1.out_data_o), 64'd15);
      check("sat20_cycles_w32", 64'(bus0.out_data_o), 64'd20);
      step();
      check("sat20_stalls_w4", 64'(bus1.out_data_o), 64'd15);
      step();
      check("mid_idx2", 64'(bus0.out_idx_o), 64'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_valid0", 64'(bus0.out_valid_o), 64'd0);
      check("mid_busy0",  64'(busy0),            64'd0);
      check("mid_valid1", 64'(bus1.out_valid_o), 64'd0);
      check("mid_busy1",  64'(busy1),            64'd0);
      check("mid_idx",    64'(bus0.out_idx_o),   64'd0);
      read_stream(1'b0, w0, w1);
      check("mid_cycles_zero",  64'(w0[0]), 64'd0);
      check("mid_retired_zero", 64'(w1[3]), 64'd0);

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
